rr_requester: RTL

- Requester-side companion to the 4-way round-robin arbiter; it drives the arbiter's req[3:0] and consumes its one-hot grant[3:0].
- Each of N clients queues burst commands into a private FIFO. A non-empty FIFO raises that client's req.
- On grant, the winning client's head command is streamed onto a shared valid/ready bus. Afterwards req is released for one cycle so the arbiter can rotate.
- Sits between client logic and the arbiter plus shared sink.

---
 rtl/rr_pkg.sv | 31 +++
 rtl/req_fifo.sv | 42 ++++
 rtl/rr_requester.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin requester slice.
package rr_pkg;

  localparam int unsigned N_CLIENTS_DEF = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned LEN_W_DEF     = 3;
  localparam int unsigned IDX_W_DEF     = $clog2(N_CLIENTS_DEF);

  typedef enum logic [1:0] {IDLE, XFER, REL} state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [LEN_W_DEF-1:0]  len;
  } cmd_t;

  typedef struct packed {
    logic                 valid;
    logic [IDX_W_DEF-1:0] idx;
  } onehot_t;

  function automatic onehot_t onehot_idx(input logic [N_CLIENTS_DEF-1:0] v);
    onehot_t r;
    r.valid = (v != '0) && ((v & (v - N_CLIENTS_DEF'(1))) == '0);
    r.idx   = '0;
    for (int unsigned i = 0; i < N_CLIENTS_DEF; i++) begin
      if (v[i]) r.idx = IDX_W_DEF'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-clock per-client command FIFO; pointers carry a wrap bit to tell full from empty.
module req_fifo
  import rr_pkg::*;
#(
  parameter type         T     = cmd_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int unsigned AW = $clog2(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + (AW+1)'(1);
      if (pop && !empty) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_q[AW-1:0]] <= din;
  end

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign head  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/rr_requester.sv
// Requester side of a 4-way round-robin arbiter: per-client command FIFOs raise req,
// the granted client's head command is streamed as a burst on a shared valid/ready bus.
module rr_requester
  import rr_pkg::*;
#(
  parameter int unsigned N_CLIENTS = N_CLIENTS_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CLIENTS-1:0]         push_valid,
  output logic [N_CLIENTS-1:0]         push_ready,
  input  logic [N_CLIENTS*DATA_W-1:0]  push_data,
  input  logic [N_CLIENTS*LEN_W-1:0]   push_len,
  output logic [N_CLIENTS-1:0]         req,
  input  logic [N_CLIENTS-1:0]         grant,
  output logic                         bus_valid,
  input  logic                         bus_ready,
  output logic [DATA_W-1:0]            bus_data,
  output logic [$clog2(N_CLIENTS)-1:0] bus_src,
  output logic                         bus_last,
  output logic                         proto_err
);

  localparam int unsigned SRC_W = $clog2(N_CLIENTS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } burst_cmd_t;

  burst_cmd_t           head [N_CLIENTS];
  logic [N_CLIENTS-1:0] full;
  logic [N_CLIENTS-1:0] empty;
  logic [N_CLIENTS-1:0] pop;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     owner_q, owner_d;
  burst_cmd_t           burst_q, burst_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic                 err_q, err_d;
  onehot_t              gnt_oh;
  logic [SRC_W-1:0]     gnt_idx;

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_fifo
    burst_cmd_t din;
    assign din = {push_data[g*DATA_W +: DATA_W], push_len[g*LEN_W +: LEN_W]};

    req_fifo #(
      .T     (burst_cmd_t),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_valid[g] && push_ready[g]),
      .din   (din),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  assign push_ready = ~full;

  // The owner keeps req high for the whole burst, then drops it for one cycle so the arbiter rotates.
  always_comb begin
    req = ~empty;
    if (state_q == XFER)     req[owner_q] = 1'b1;
    else if (state_q == REL) req[owner_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    pop     = '0;
    gnt_oh  = onehot_idx(grant);
    gnt_idx = gnt_oh.idx;
    case (state_q)
      IDLE: begin
        if (gnt_oh.valid && req[gnt_idx]) begin
          pop[gnt_idx] = 1'b1;
          owner_d      = gnt_idx;
          burst_d      = head[gnt_idx];
          beat_d       = '0;
          state_d      = XFER;
        end else if (grant != '0) begin
          err_d = 1'b1;
        end
      end
      XFER: begin
        if (!grant[owner_q]) err_d = 1'b1;
        if (bus_ready) begin
          if (bus_last) state_d = REL;
          else          beat_d  = beat_q + LEN_W'(1);
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign bus_valid = (state_q == XFER);
  assign bus_src   = bus_valid ? owner_q : '0;
  assign bus_last  = bus_valid && (beat_q == burst_q.len);
  assign bus_data  = bus_valid ? burst_q.data + DATA_W'(beat_q) : '0;
  assign proto_err = err_q;

endmodule
